vblank_scheduler: RTL and testbench

- Sequences game-logic update requesters (target, crosshair, score, ...) so that each gets exclusive write access to shared frame state only during vertical blanking.
- Starts on the `frame` pulse from the VGA sync generator and grants requesters one at a time, round-robin.
- Enforces a deadline line so no update is still running when active display restarts at line 0.
- Sits between the VGA sync generator and the per-object update FSMs.

---
 rtl/vga_pkg.sv | 15 +
 rtl/vblank_scheduler.sv | 157 +++++++++++++++
 tb/tb_vblank_scheduler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the vertical-blank scheduler state type.
package vga_pkg;

   localparam int H_TOTAL  = 800;
   localparam int V_TOTAL  = 525;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      GRANT = 2'd2
   } sched_state_t;

endpackage

// File: rtl/vblank_scheduler.sv
// Hands out exclusive access to shared frame state during vertical blanking.
// Requesters are visited once per accepted frame in round-robin order. The
// start index rotates every frame. All work is cut off at the deadline line,
// so no update is still running when active video restarts.
module vblank_scheduler
   import vga_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int DEADLINE_LINE = 515,
   parameter int MAX_GRANT     = 4096,
   parameter int CNT_W         = 16
)
(
   input  logic             clk25,
   input  logic             reset,
   input  logic             frame,
   input  logic [9:0]       y,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] grant,
   output logic             busy,
   output logic             overrun,
   output logic [CNT_W-1:0] frame_count
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = (MAX_GRANT > 1) ? $clog2(MAX_GRANT) : 1;
   localparam logic [IW-1:0] LAST_IDX   = IW'(N_REQ - 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(MAX_GRANT - 1);
   localparam logic [9:0]    DEADLINE_Y = 10'(DEADLINE_LINE);
   localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);

   sched_state_t     state, state_nxt;
   logic [N_REQ-1:0] pending, pending_nxt;
   logic [N_REQ-1:0] grant_nxt;
   logic [IW-1:0]    idx, idx_nxt, idx_inc;
   logic [IW-1:0]    cnt, cnt_nxt;
   logic [IW-1:0]    rr_ptr, rr_nxt, rr_inc;
   logic [TW-1:0]    timer, timer_nxt;
   logic             overrun_nxt;
   logic [CNT_W-1:0] frame_count_nxt;
   logic             scan_last;
   logic             deadline_hit;

   // Wrap-around increments are done by compare, so N_REQ need not be a power of two.
   always_comb begin
      idx_inc      = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      rr_inc       = (rr_ptr == LAST_IDX) ? '0 : rr_ptr + 1'b1;
      scan_last    = (cnt == LAST_IDX);
      deadline_hit = (state != IDLE) && (y == DEADLINE_Y);
   end

   // Next-state logic. The deadline overrides everything, then done, then the grant timeout.
   always_comb begin
      state_nxt       = state;
      pending_nxt     = pending;
      grant_nxt       = grant;
      idx_nxt         = idx;
      cnt_nxt         = cnt;
      rr_nxt          = rr_ptr;
      timer_nxt       = timer;
      overrun_nxt     = overrun;
      frame_count_nxt = frame_count;

      if (deadline_hit) begin
         grant_nxt   = '0;
         pending_nxt = '0;
         overrun_nxt = 1'b1;
         rr_nxt      = rr_inc;
         state_nxt   = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (frame) begin
                  pending_nxt     = req;
                  idx_nxt         = rr_ptr;
                  cnt_nxt         = '0;
                  frame_count_nxt = frame_count + 1'b1;
                  state_nxt       = SCAN;
               end
            end

            SCAN: begin
               if (frame) begin
                  overrun_nxt = 1'b1;
               end
               if (pending[idx]) begin
                  grant_nxt = ONE << idx;
                  timer_nxt = '0;
                  state_nxt = GRANT;
               end else if (scan_last) begin
                  rr_nxt    = rr_inc;
                  state_nxt = IDLE;
               end else begin
                  idx_nxt = idx_inc;
                  cnt_nxt = cnt + 1'b1;
               end
            end

            GRANT: begin
               if (frame) begin
                  overrun_nxt = 1'b1;
               end
               timer_nxt = timer + 1'b1;
               if (done[idx] || (timer == TIMER_LAST)) begin
                  if (!done[idx]) begin
                     overrun_nxt = 1'b1;
                  end
                  grant_nxt        = '0;
                  pending_nxt[idx] = 1'b0;
                  if (scan_last) begin
                     rr_nxt    = rr_inc;
                     state_nxt = IDLE;
                  end else begin
                     idx_nxt   = idx_inc;
                     cnt_nxt   = cnt + 1'b1;
                     state_nxt = SCAN;
                  end
               end
            end

            default: begin
               grant_nxt = '0;
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk25) begin
      if (reset) begin
         state       <= IDLE;
         pending     <= '0;
         grant       <= '0;
         idx         <= '0;
         cnt         <= '0;
         rr_ptr      <= '0;
         timer       <= '0;
         overrun     <= 1'b0;
         frame_count <= '0;
      end else begin
         state       <= state_nxt;
         pending     <= pending_nxt;
         grant       <= grant_nxt;
         idx         <= idx_nxt;
         cnt         <= cnt_nxt;
         rr_ptr      <= rr_nxt;
         timer       <= timer_nxt;
         overrun     <= overrun_nxt;
         frame_count <= frame_count_nxt;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_vblank_scheduler.sv
// Scoreboard bench for vblank_scheduler. Expected grant events (value and
// cycle of first visibility) are queued when a frame is issued. A negedge
// monitor pops and compares them on every rising grant.
module tb_vblank_scheduler;
   import vga_pkg::*;

   logic        clk25 = 1'b0;
   logic        reset;
   logic        frame;
   logic [9:0]  y;
   logic [3:0]  req;
   logic [3:0]  done;
   logic [3:0]  grant;
   logic        busy;
   logic        overrun;
   logic [15:0] frame_count;

   int cycle  = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] g;
      int         at;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   logic [3:0] prev_grant = 4'b0000;

   vblank_scheduler #(
      .N_REQ(4),
      .DEADLINE_LINE(515),
      .MAX_GRANT(16),
      .CNT_W(16)
   ) dut (
      .clk25(clk25),
      .reset(reset),
      .frame(frame),
      .y(y),
      .req(req),
      .done(done),
      .grant(grant),
      .busy(busy),
      .overrun(overrun),
      .frame_count(frame_count)
   );

   // 25 MHz clock.
   always #20 clk25 = ~clk25;

   // Cycle counter; the value read at a negedge names the preceding posedge.
   always @(posedge clk25) cycle <= cycle + 1;

   // Monitor: every rising grant must match the next queued expectation.
   always @(negedge clk25) begin
      if (grant != 4'b0000 && prev_grant == 4'b0000) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_grant actual=%b at cycle %0d required=none", grant, cycle);
         end else begin
            mon_e = expq.pop_front();
            if (grant !== mon_e.g || cycle != mon_e.at) begin
               errors++;
               $display("[TB] FAIL grant_event actual=%b@%0d required=%b@%0d",
                        grant, cycle, mon_e.g, mon_e.at);
            end
         end
      end
      prev_grant = grant;
   end

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(negedge clk25);
   endtask

   task automatic waitUntil(input int c);
      while (cycle < c) tick();
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cycle);
      end
   endtask

   task automatic expectGrant(input logic [3:0] g, input int at);
      exp_t e;
      e.g  = g;
      e.at = at;
      expq.push_back(e);
   endtask

   // Pulses frame with the given request mask; f is the cycle at which frame is sampled.
   task automatic applyStimulus(input logic [3:0] r, output int f);
      req   = r;
      frame = 1'b1;
      f     = cycle + 1;
      tick();
      frame = 1'b0;
   endtask

   task automatic applyReset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Waits for a grant, holds it for 'hold' cycles, then strobes done on it.
   task automatic serveGrant(input int hold);
      int guard = 0;
      while (grant == 4'b0000 && guard < 200) begin
         tick();
         guard++;
      end
      if (grant == 4'b0000) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_grant actual=0000 required=nonzero at cycle %0d", cycle);
      end else begin
         repeat (hold) tick();
         done = grant;
         tick();
         done = 4'b0000;
      end
   endtask

   initial begin
      int f;
      int f2;
      logic [3:0] one;
      one   = 4'b0001;
      reset = 1'b1;
      frame = 1'b0;
      y     = 10'd0;
      req   = 4'b0000;
      done  = 4'b0000;
      tick();
      tick();
      reset = 1'b0;

      checkOutput("reset_grant", 32'(grant), 32'h0);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      checkOutput("reset_overrun", 32'(overrun), 32'h0);
      checkOutput("reset_frame_count", 32'(frame_count), 32'h0);

      // Basic sequence: req 0101 from rr_ptr 0.
      applyStimulus(4'b0101, f);
      expectGrant(4'b0001, f + 1);
      expectGrant(4'b0100, f + 4);
      serveGrant(0);
      serveGrant(0);
      waitUntil(f + 6);
      checkOutput("t1_busy_idle", 32'(busy), 32'h0);
      checkOutput("t1_overrun", 32'(overrun), 32'h0);
      checkOutput("t1_frame_count", 32'(frame_count), 32'h1);

      // Four full frames; start index rotates 1,2,3,0.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(4'b1111, f);
         for (int j = 0; j < 4; j++) begin
            expectGrant(one << ((k + 1 + j) % 4), f + 1 + 2 * j);
         end
         for (int j = 0; j < 4; j++) serveGrant(0);
         waitUntil(f + 8);
         checkOutput("t2_busy_idle", 32'(busy), 32'h0);
         checkOutput("t2_frame_count", 32'(frame_count), 32'(2 + k));
      end

      // Grant timeout with MAX_GRANT=16, rr_ptr now 1.
      applyStimulus(4'b0110, f);
      expectGrant(4'b0010, f + 1);
      expectGrant(4'b0100, f + 18);
      waitUntil(f + 16);
      checkOutput("t3_grant_held", 32'(grant), 32'h2);
      checkOutput("t3_overrun_before", 32'(overrun), 32'h0);
      waitUntil(f + 17);
      checkOutput("t3_grant_dropped", 32'(grant), 32'h0);
      checkOutput("t3_overrun_after", 32'(overrun), 32'h1);
      serveGrant(0);
      waitUntil(f + 20);
      checkOutput("t3_busy_scanning", 32'(busy), 32'h1);
      waitUntil(f + 21);
      checkOutput("t3_busy_idle", 32'(busy), 32'h0);

      applyReset();
      checkOutput("rst2_overrun", 32'(overrun), 32'h0);
      checkOutput("rst2_frame_count", 32'(frame_count), 32'h0);

      // Deadline line hit mid-grant; remaining requesters get nothing.
      applyStimulus(4'b1011, f);
      expectGrant(4'b0001, f + 1);
      waitUntil(f + 5);
      y = 10'd515;
      tick();
      y = 10'd0;
      checkOutput("t4_grant_cut", 32'(grant), 32'h0);
      checkOutput("t4_busy", 32'(busy), 32'h0);
      checkOutput("t4_overrun", 32'(overrun), 32'h1);
      waitUntil(f + 20);

      // Frame while busy, then reset mid-grant.
      applyReset();
      applyStimulus(4'b0001, f);
      expectGrant(4'b0001, f + 1);
      waitUntil(f + 3);
      frame = 1'b1;
      tick();
      frame = 1'b0;
      checkOutput("t5_frame_count", 32'(frame_count), 32'h1);
      checkOutput("t5_overrun", 32'(overrun), 32'h1);
      checkOutput("t5_grant_kept", 32'(grant), 32'h1);
      waitUntil(f + 6);
      checkOutput("t5_grant_still", 32'(grant), 32'h1);
      reset = 1'b1;
      tick();
      checkOutput("t5_rst_grant", 32'(grant), 32'h0);
      checkOutput("t5_rst_busy", 32'(busy), 32'h0);
      checkOutput("t5_rst_frame_count", 32'(frame_count), 32'h0);
      checkOutput("t5_rst_overrun", 32'(overrun), 32'h0);
      reset = 1'b0;
      tick();

      // Empty request: four scan cycles, no grant, rr_ptr still advances.
      checkOutput("t6_busy_before", 32'(busy), 32'h0);
      applyStimulus(4'b0000, f);
      for (int k = 0; k < 4; k++) begin
         waitUntil(f + k);
         checkOutput("t6_busy_scan", 32'(busy), 32'h1);
      end
      waitUntil(f + 4);
      checkOutput("t6_busy_after", 32'(busy), 32'h0);
      applyStimulus(4'b1111, f2);
      expectGrant(4'b0010, f2 + 1);
      expectGrant(4'b0100, f2 + 3);
      expectGrant(4'b1000, f2 + 5);
      expectGrant(4'b0001, f2 + 7);
      for (int j = 0; j < 4; j++) serveGrant(0);
      waitUntil(f2 + 8);
      checkOutput("t6_busy_end", 32'(busy), 32'h0);
      checkOutput("t6_frame_count", 32'(frame_count), 32'h2);

      repeat (4) tick();
      checkOutput("scoreboard_drained", 32'(expq.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
